// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage buffer (pipe_stage_buf).
package pipe_pkg;

  localparam int unsigned PIPE_CTRL_W = 12;
  localparam int unsigned PIPE_DATA_W = 197;
  localparam int unsigned PIPE_PC_W   = 32;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  // Bit positions inside the control bundle
  localparam int unsigned CTRL_BRANCH     = 0;
  localparam int unsigned CTRL_MEMREAD    = 1;
  localparam int unsigned CTRL_MEMTOREG   = 2;
  localparam int unsigned CTRL_MEMWRITE   = 3;
  localparam int unsigned CTRL_ALUSRC     = 4;
  localparam int unsigned CTRL_REGWRITE   = 5;
  localparam int unsigned CTRL_JUMP       = 6;
  localparam int unsigned CTRL_ALUCTL_LSB = 7;
  localparam int unsigned CTRL_ALUCTL_MSB = 10;

  function automatic logic [1:0] occ_of(pipe_state_t s);
    case (s)
      PS_ONE:  return 2'd1;
      PS_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream valid/ready bundle of one pipeline stage.
// Handshake: a beat moves on an edge where valid & ready are both 1; valid never waits on ready.
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned PC_W   = PIPE_PC_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;

  modport master (
    output in_valid, in_ctrl, in_data, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_pc
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_pc
  );
endinterface

// File: rtl/pipe_entry.sv
// One {valid, ctrl, data, pc} holding register of the stage buffer.
// PIPE_ZERO_BUBBLE_EN: also clear data/pc whenever the entry is killed.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned PC_W   = PIPE_PC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]   d_pc,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [PC_W-1:0]   q_pc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
      q_pc    <= '0;
    end else if (flush || (drop && !load)) begin
      // A dead entry must look like a NOP downstream
      q_valid <= 1'b0;
      q_ctrl  <= '0;
`ifdef PIPE_ZERO_BUBBLE_EN
      q_data  <= '0;
      q_pc    <= '0;
`endif
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: main + skid entry, registered in_ready, synchronous flush.
// Optional PIPE_ZERO_BUBBLE_EN zeroes data/pc of invalid entries as well as control.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned PC_W   = PIPE_PC_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  pipe_stage_buf_if.slave        bus,
  output logic [1:0]             occupancy,
  output pipe_state_t            dbg_state
);

  pipe_state_t state_q, state_d;

  logic accept, take;
  logic main_load, main_from_skid, main_drop;
  logic skid_load, skid_drop;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [PC_W-1:0]   main_pc, skid_pc, main_d_pc;

  // Handshake qualifiers depend only on the state register, never on out_ready
  assign bus.in_ready  = (state_q != PS_TWO);
  assign bus.out_valid = (state_q != PS_EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign take          = bus.out_valid & bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= PS_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = PS_ONE;
        end
      end
      PS_ONE: begin
        if (accept && take) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = PS_TWO;
        end else if (take) begin
          main_drop = 1'b1;
          state_d   = PS_EMPTY;
        end
      end
      PS_TWO: begin
        if (take) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
          state_d        = PS_ONE;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    if (flush) state_d = PS_EMPTY;
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : bus.in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : bus.in_data;
  assign main_d_pc   = main_from_skid ? skid_pc   : bus.in_pc;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) u_main (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .load    (main_load),
    .drop    (main_drop),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .d_pc    (main_d_pc),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (main_data),
    .q_pc    (main_pc)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .load    (skid_load),
    .drop    (skid_drop),
    .d_ctrl  (bus.in_ctrl),
    .d_data  (bus.in_data),
    .d_pc    (bus.in_pc),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data),
    .q_pc    (skid_pc)
  );

  assign bus.out_ctrl = main_ctrl;
  assign bus.out_data = main_data;
  assign bus.out_pc   = main_pc;
  assign occupancy    = occ_of(state_q);
  assign dbg_state    = state_q;

  // Entry valid bits must always agree with the state encoding
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ((main_valid == (state_q != PS_EMPTY)) && (skid_valid == (state_q == PS_TWO)));
    end
  end

endmodule
